// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU / multiply-accumulate execute unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_AND    = 4'b0010,
    OP_OR     = 4'b0011,
    OP_MAC    = 4'b0100,
    OP_SLT    = 4'b0101,
    OP_MUL    = 4'b0110,
    OP_CLRACC = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  localparam int unsigned ILLEGAL_RESULT = 32'd0;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier returning the low WIDTH product bits.
// last_o flags the final step; product_o then carries the completed product.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] prod_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] prod_d;

  assign prod_d    = prod_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
  assign last_o    = (count_q == CW'(1));
  assign product_o = prod_d;

  // A non-zero count means a multiplication is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      prod_q   <= '0;
      count_q  <= CW'(WIDTH);
    end else if (count_q != '0) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mac_unit.sv
// Multi-cycle ALU execute unit with a persistent accumulator and valid/ready
// handshakes on both sides; MUL/MAC run through the sequential multiplier.
module alu_mac_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [WIDTH-1:0] acc
);

  // Returns {overflow, carry, sum} of x + y + cin.
  function automatic logic [WIDTH+1:0] add_cv(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             cin);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    return {(x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]),
            s[WIDTH], s[WIDTH-1:0]};
  endfunction

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q, overflow_q, zero_q, negative_q;
  logic             is_mac_q;

  logic [WIDTH-1:0] res_d;
  logic             carry_d, ovf_d;
  logic [WIDTH+1:0] sum_s, diff_s, mac_s;
  logic [WIDTH-1:0] product_s;
  logic             mul_last_s, is_mul_op_s, mul_start_s;

  assign is_mul_op_s = (op == OP_MUL) || (op == OP_MAC);
  assign mul_start_s = (state_q == ST_IDLE) && in_valid && is_mul_op_s;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start_s),
    .a_i      (a),
    .b_i      (b),
    .last_o   (mul_last_s),
    .product_o(product_s)
  );

  assign sum_s  = add_cv(a, b, 1'b0);
  assign diff_s = add_cv(a, ~b, 1'b1);
  assign mac_s  = add_cv(acc_q, product_s, 1'b0);

  // Next result/flags: multiplier path while busy, otherwise the single-cycle op.
  always_comb begin
    res_d   = WIDTH'(ILLEGAL_RESULT);
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    if (state_q == ST_BUSY) begin
      if (is_mac_q) begin
        {ovf_d, carry_d, res_d} = mac_s;
      end else begin
        res_d = product_s;
      end
    end else begin
      case (op)
        OP_ADD:    {ovf_d, carry_d, res_d} = sum_s;
        OP_SUB:    {ovf_d, carry_d, res_d} = diff_s;
        OP_AND:    res_d = a & b;
        OP_OR:     res_d = a | b;
        OP_SLT:    res_d = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ diff_s[WIDTH+1]};
        OP_CLRACC: res_d = acc_q;
        default:   res_d = WIDTH'(ILLEGAL_RESULT);
      endcase
    end
  end

  // Control FSM; result, flags and accumulator only move when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      is_mac_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_mul_op_s) begin
              is_mac_q <= (op == OP_MAC);
              state_q  <= ST_BUSY;
            end else begin
              result_q   <= res_d;
              carry_q    <= carry_d;
              overflow_q <= ovf_d;
              zero_q     <= ~|res_d;
              negative_q <= res_d[WIDTH-1];
              if (op == OP_CLRACC) acc_q <= '0;
              state_q    <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (mul_last_s) begin
            result_q   <= res_d;
            carry_q    <= carry_d;
            overflow_q <= ovf_d;
            zero_q     <= ~|res_d;
            negative_q <= res_d[WIDTH-1];
            if (is_mac_q) acc_q <= res_d;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_mac_unit.sv
// Self-checking bench for alu_mac_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the accumulator unit.
module tb_alu_mac_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] result, acc;
  logic        carry, overflow, zero, negative;

  int total = 0;
  int bad = 0;
  logic [31:0] m_acc = 32'd0;
  int          lat;
  logic [31:0] r, ac, er;
  logic [3:0]  fl, ef;

  alu_mac_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero),
    .negative(negative), .acc(acc)
  );

  always #5 clk = ~clk;

  function automatic logic ovf64(input longint t);
    return (t > 64'sd2147483647) || (t < -64'sd2147483648);
  endfunction

  // Reference model: flags returned as {carry, overflow, zero, negative}.
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] ma, output logic [31:0] res, output logic [3:0] f);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    logic [63:0] full = 64'(x) * 64'(y);
    logic [31:0] p = full[31:0];
    logic c = 1'b0, v = 1'b0;
    case (o)
      4'd0: begin res = x + y; c = (64'(x) + 64'(y)) >= 64'h1_0000_0000; v = ovf64(sx + sy); end
      4'd1: begin res = x - y; c = (x >= y); v = ovf64(sx - sy); end
      4'd2: res = x & y;
      4'd3: res = x | y;
      4'd4: begin
        res = ma + p;
        c = (64'(ma) + 64'(p)) >= 64'h1_0000_0000;
        v = ovf64(longint'($signed(ma)) + longint'($signed(p)));
        ma = res;
      end
      4'd5: res = (sx < sy) ? 32'd1 : 32'd0;
      4'd6: res = p;
      4'd7: begin res = ma; ma = 32'd0; end
      default: res = 32'd0;
    endcase
    f = {c, v, res == 32'd0, res[31]};
  endfunction

  // Issue one op from a negedge; returns latency and the captured outputs at
  // the first negedge where out_valid is seen. Leaves the result unconsumed.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
      if (out_valid) begin lat = i; break; end
    end
    r = result; fl = {carry, overflow, zero, negative}; ac = acc;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL reset_hs got=%b want=10", {in_ready, out_valid}); end
    total++;
    if ({result, acc, carry, overflow, zero, negative} !== 68'd0) begin
      bad++; $display("FAIL reset_regs result=%h acc=%h flags=%b want all zero", result, acc, {carry, overflow, zero, negative});
    end
  endtask

  task automatic test_add();
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1);
    total++;
    if ({r, fl} !== {32'h8000_0000, 4'b0101}) begin bad++; $display("FAIL add_ovf got=%h/%b want=80000000/0101", r, fl); end
    total++;
    if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
    consume();
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1);
    total++;
    if ({r, fl} !== {32'h0, 4'b1010}) begin bad++; $display("FAIL add_carry got=%h/%b want=00000000/1010", r, fl); end
    consume();
  endtask

  task automatic test_sub_slt();
    run_op(4'd1, 32'd3, 32'd5);
    total++;
    if ({r, fl} !== {32'hFFFF_FFFE, 4'b0001}) begin bad++; $display("FAIL sub_borrow got=%h/%b want=fffffffe/0001", r, fl); end
    consume();
    run_op(4'd5, 32'h8000_0000, 32'd1);
    total++;
    if (r !== 32'd1) begin bad++; $display("FAIL slt_neg got=%h want=1", r); end
    consume();
    run_op(4'd5, 32'd1, 32'h8000_0000);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL slt_pos got=%h want=0", r); end
    consume();
  endtask

  task automatic test_mul_mac();
    run_op(4'd6, 32'h0001_0000, 32'h0001_0000);
    total++;
    if ({r, fl[1]} !== {32'h0, 1'b1}) begin bad++; $display("FAIL mul_wrap got=%h z=%b want=0 z=1", r, fl[1]); end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
    total++;
    if (ac !== m_acc) begin bad++; $display("FAIL mul_acc got=%h want=%h", ac, m_acc); end
    consume();
    run_op(4'd4, 32'd3, 32'd4);
    total++;
    if ({r, ac} !== {32'd12, 32'd12}) begin bad++; $display("FAIL mac1 got=%0d acc=%0d want=12", r, ac); end
    consume();
    run_op(4'd4, 32'd5, 32'd6);
    total++;
    if ({r, ac} !== {32'd42, 32'd42}) begin bad++; $display("FAIL mac2 got=%0d acc=%0d want=42", r, ac); end
    consume();
    run_op(4'd7, 32'd0, 32'd0);
    total++;
    if ({r, ac} !== {32'd42, 32'd0}) begin bad++; $display("FAIL clracc got=%0d acc=%0d want=42/0", r, ac); end
    consume();
    m_acc = 32'd0;
  endtask

  task automatic test_backpressure();
    model(4'd4, 32'd7, 32'd2, m_acc, er, ef);
    run_op(4'd4, 32'd7, 32'd2);
    total++;
    if ({r, fl, ac} !== {er, ef, m_acc}) begin bad++; $display("FAIL bp_result got=%h/%b/%h want=%h/%b/%h", r, fl, ac, er, ef, m_acc); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({result, carry, overflow, zero, negative, acc, in_ready, out_valid} !== {r, fl, ac, 2'b01}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%h/%h rdy=%b vld=%b want=%h/%h 0 1", i, result, acc, in_ready, out_valid, r, ac);
      end
    end
    consume();
    total++;
    if ({in_ready, acc} !== {1'b1, m_acc}) begin bad++; $display("FAIL bp_release rdy=%b acc=%h want=1/%h", in_ready, acc, m_acc); end
  endtask

  task automatic test_illegal();
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    total++;
    if ({r, fl, ac} !== {32'h0, 4'b0010, m_acc}) begin bad++; $display("FAIL illegal got=%h/%b/%h want=0/0010/%h", r, fl, ac, m_acc); end
    consume();
  endtask

  task automatic test_back_to_back();
    int acc_cnt;
    logic [3:0] ops [2] = '{4'd0, 4'd6};
    int ncyc [2] = '{20, 68};
    int want [2] = '{10, 2};
    for (int t = 0; t < 2; t++) begin
      acc_cnt = 0;
      out_ready = 1'b1;
      for (int i = 0; i < ncyc[t]; i++) begin
        op = ops[t]; a = $urandom; b = $urandom; in_valid = 1'b1;
        if (in_ready) acc_cnt++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (acc_cnt !== want[t]) begin bad++; $display("FAIL throughput op=%0d got=%0d want=%0d", ops[t], acc_cnt, want[t]); end
    end
    total++;
    if (acc !== m_acc) begin bad++; $display("FAIL b2b_acc got=%h want=%h", acc, m_acc); end
  endtask

  task automatic test_random();
    logic [31:0] specials [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] x, y;
    logic [3:0]  o;
    int          wl;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      model(o, x, y, m_acc, er, ef);
      wl = (o == 4'd4 || o == 4'd6) ? 33 : 1;
      run_op(o, x, y);
      total++;
      if ({r, fl, ac} !== {er, ef, m_acc} || lat !== wl) begin
        bad++; $display("FAIL rand op=%0d a=%h b=%h got=%h/%b/%h lat=%0d want=%h/%b/%h lat=%0d", o, x, y, r, fl, ac, lat, er, ef, m_acc, wl);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end
  endtask

  task automatic test_reset_mid_mac();
    if (m_acc == 32'd0) begin
      model(4'd4, 32'd9, 32'd9, m_acc, er, ef);
      run_op(4'd4, 32'd9, 32'd9);
      consume();
    end
    op = 4'd4; a = 32'd11; b = 32'd13; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b00) begin bad++; $display("FAIL midmac_busy got=%b want=00", {in_ready, out_valid}); end
    rst_n = 1'b0;
    #1;
    total++;
    if (acc !== 32'd0) begin bad++; $display("FAIL async_reset acc=%h want=0", acc); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    m_acc = 32'd0;
    total++;
    if ({in_ready, out_valid, acc, result} !== {2'b10, 64'd0}) begin
      bad++; $display("FAIL midmac_reset rdy=%b vld=%b acc=%h res=%h want=1 0 0 0", in_ready, out_valid, acc, result);
    end
    run_op(4'd4, 32'd3, 32'd4);
    total++;
    if ({r, ac, lat} !== {32'd12, 32'd12, 32'd33}) begin bad++; $display("FAIL post_reset_mac got=%0d acc=%0d lat=%0d want=12/12/33", r, ac, lat); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_mul_mac();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mac_unit.md
# alu_mac_unit

Parametrised multi-cycle ALU with a persistent internal accumulator. It is the datapath execute unit for integer ALU, multiply and multiply-accumulate operations. Single-cycle operations complete in one clock. MUL/MAC run an iterative radix-2 shift-add multiplier. Operands enter and results leave through valid/ready handshakes so the pipeline can stall around multi-cycle ops.

## Interface
- WIDTH, 32, operand/result/accumulator width (≥4)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- op  in  4  operation code (see Operation)
- a, b  in  WIDTH  operands
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- carry, overflow, zero, negative  out  1 each  registered flags
- acc  out  WIDTH  current accumulator value

## Operation
- Op codes:
  - 0000 ADD
  - 0001 SUB (a + ~b + 1)
  - 0010 AND
  - 0011 OR
  - 0100 MAC (acc + a*b)
  - 0101 SLT (signed less-than: result = {0…, N^V of a−b})
  - 0110 MUL (low WIDTH bits of a*b)
  - 0111 CLRACC (result = acc before clear; acc := 0)
  - all others ILLEGAL: result 0.
- Arithmetic is modulo 2^WIDTH. Product low bits are sign-agnostic; the multiplier is unsigned.
- Flags:
  - ADD/SUB: carry = carry-out of the WIDTH-bit add, so SUB carry = 1 means no borrow (a ≥ b unsigned). overflow = signed overflow.
  - MAC: carry/overflow come from the final acc + product add.
  - AND/OR/SLT/MUL/CLRACC/ILLEGAL: carry = overflow = 0.
  - All ops: zero = (result == 0); negative = result[WIDTH-1].
- Accumulator changes only on MAC completion (acc := result) and CLRACC (acc := 0). MUL never touches acc.
- FSM states:
  - IDLE: in_ready = 1. On accept, single-cycle ops compute and register their result, then go to DONE. MUL/MAC latch the operands, clear the partial product, load count = WIDTH, and go to BUSY.
  - BUSY: each cycle, if multiplier LSB is set, add the shifted multiplicand to the partial product. Then shift the multiplicand left and the multiplier right, and decrement count. At count = 1 the final step completes, the result and flags (plus acc for MAC) are registered, and the FSM goes to DONE.
  - DONE: out_valid = 1; result and flags are held stable. When out_ready is high, go to IDLE.
- in_ready = (state == IDLE). No request is accepted in BUSY or DONE, so a new op is never accepted in the same cycle a result is consumed.
- A request with in_valid low is ignored. Inputs are don't-care when not accepted.

## Timing
- Reset, asynchronous, any state including mid-multiply:
  - state = IDLE, in_ready = 1, out_valid = 0
  - result = 0, all flags = 0, acc = 0
  - multiplier registers cleared
- Latency, accept edge to out_valid high:
  - single-cycle ops: 1 cycle
  - MUL/MAC: WIDTH + 1 cycles
- Throughput:
  - single-cycle ops: one per 2 cycles when out_ready is held high
  - MUL/MAC: one per WIDTH + 2 cycles
- out_valid remains high indefinitely while out_ready = 0. Result, flags and acc must not change.
- acc updates on the same edge out_valid rises (MAC/CLRACC).
- in_valid and out_ready may toggle arbitrarily. The unit never drops or duplicates an op.

## Structure
- Shared package `alu_pkg`:
  - typedef `alu_op_e` (4-bit enum, codes above)
  - FSM state typedef `alu_state_e` (IDLE, BUSY, DONE)
  - constant for the ILLEGAL result value
- One natural sub-module, `seq_multiplier`:
  - iterative radix-2 shift-add core, parametrised by WIDTH
  - start/done handshake with the parent FSM
  - returns low WIDTH product bits
- The parent owns the accumulator, flag logic, handshake and final MAC add.

## Test plan
- Reset and accumulator: reset mid-MAC (e.g. 5 cycles after accept) → next cycle in_ready = 1, out_valid = 0, acc = 0.
- ADD, WIDTH = 32:
  - a = 0x7FFFFFFF, b = 1 → result 0x80000000, overflow = 1, negative = 1, carry = 0, one cycle after accept.
  - a = 0xFFFFFFFF, b = 1 → result 0, carry = 1, zero = 1.
- SUB and SLT:
  - SUB a = 3, b = 5 → result 0xFFFFFFFE, carry = 0, negative = 1.
  - SLT a = 0x80000000, b = 1 → result 1.
  - SLT a = 1, b = 0x80000000 → result 0.
- MUL/MAC sequence:
  - MUL 0x10000 × 0x10000 → result 0, zero = 1, acc unchanged, out_valid exactly 33 cycles after accept.
  - MAC 3×4, then MAC 5×6 → results 12 then 42, acc = 42.
  - CLRACC → result 42, acc = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after a MAC completes → result, flags and acc stable, in_ready = 0 throughout. Release → IDLE next cycle, acc incremented only once.
- Illegal op 1111 → result 0, zero = 1, carry = overflow = 0, acc unchanged.
